// File: rtl/need_scheduler_if.sv
// need_scheduler_if: care-request handshake and need-state outputs of the pet
// core scheduler, shared between the scheduler and its consumers.
interface need_scheduler_if;
   logic        test_mode;
   logic        care_valid;
   logic [2:0]  care_sel;
   logic        care_ready;
   logic [14:0] levels;
   logic [2:0]  health;
   logic        dead;
   logic        upd_valid;
   logic [2:0]  upd_idx;

   // Requester / observer side (button logic, display path, bench)
   modport master (
      output test_mode, care_valid, care_sel,
      input  care_ready, levels, health, dead, upd_valid, upd_idx
   );

   // Scheduler side
   modport slave (
      input  test_mode, care_valid, care_sel,
      output care_ready, levels, health, dead, upd_valid, upd_idx
   );
endinterface

// File: rtl/need_scheduler.sv
// need_scheduler: one-second prescaler, five need-decay timers, and an arbiter
// that merges care requests and decay expiries onto a single level-update
// path. Owns the need levels, the health level and the sticky death flag.
module need_scheduler #(
   parameter int unsigned TICK_DIV        = 32'd50_000_000,
   parameter int unsigned SLEEP_PERIOD    = 32'd3600,
   parameter int unsigned FOOD_PERIOD     = 32'd600,
   parameter int unsigned BATH_PERIOD     = 32'd1200,
   parameter int unsigned MUSIC_PERIOD    = 32'd900,
   parameter int unsigned EXERCISE_PERIOD = 32'd1800,
   parameter int unsigned TEST_PERIOD     = 32'd2,
   parameter int unsigned CARE_STEP       = 32'd2
) (
   input  logic            clk,
   input  logic            reset,
   need_scheduler_if.slave sched
);

   localparam int          NUM_NEEDS = 32'sd5;
   localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 32'd1);
   localparam logic [2:0]  LVL_MAX   = 3'd7;

   // Registered state
   logic [25:0] r_presc;
   logic [11:0] r_cnt [NUM_NEEDS];
   logic        r_mode;
   logic [4:0]  r_pending;
   logic [2:0]  r_ptr;
   logic [2:0]  r_lvl [NUM_NEEDS];
   logic [2:0]  r_health;
   logic        r_dead;
   logic        r_upd_valid;
   logic [2:0]  r_upd_idx;

   // Combinational decode
   logic        w_sec_tick;
   logic        w_mode_chg;
   logic [4:0]  w_expire;
   logic        w_care_acc;
   logic        w_care_hit;
   logic        w_grant_valid;
   logic [2:0]  w_grant_idx;
   logic [2:0]  w_grant_lvl;
   logic        w_decay_go;
   logic [4:0]  w_clear;
   logic [4:0]  w_pending_nxt;

   // Final counter value before wrap for need idx under the current mode
   function automatic logic [11:0] last_count(input logic [2:0] idx, input logic tm);
      int unsigned p;
      if (tm) begin
         p = TEST_PERIOD;
      end else begin
         case (idx)
            3'd0:    p = SLEEP_PERIOD;
            3'd1:    p = FOOD_PERIOD;
            3'd2:    p = BATH_PERIOD;
            3'd3:    p = MUSIC_PERIOD;
            3'd4:    p = EXERCISE_PERIOD;
            default: p = SLEEP_PERIOD;
         endcase
      end
      return 12'(p - 32'd1);
   endfunction

   // Reduce a value in 0..9 modulo 5
   function automatic logic [2:0] wrap5(input logic [3:0] v);
      logic [2:0] res;
      if (v >= 4'd5) begin
         res = 3'(v - 4'd5);
      end else begin
         res = v[2:0];
      end
      return res;
   endfunction

   // Round-robin search: first set pending flag from ptr upward, modulo 5.
   // Returns {found, index}.
   function automatic logic [3:0] rr_pick(input logic [4:0] pend, input logic [2:0] ptr);
      logic       found;
      logic [2:0] idx;
      logic [2:0] cand;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 32'sd0; k < NUM_NEEDS; k++) begin
         cand = wrap5({1'b0, ptr} + 4'(k));
         if (!found && pend[cand]) begin
            found = 1'b1;
            idx   = cand;
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   // Level after a care request, saturating at the maximum level
   function automatic logic [2:0] care_sum(input logic [2:0] lvl);
      int unsigned s;
      logic [2:0]  res;
      s = 32'(lvl) + CARE_STEP;
      if (s > 32'(LVL_MAX)) begin
         res = LVL_MAX;
      end else begin
         res = 3'(s);
      end
      return res;
   endfunction

   // Second tick, mode-change detection and per-need expiry
   always_comb begin
      w_sec_tick = (r_presc == TICK_LAST);
      w_mode_chg = (sched.test_mode != r_mode);
      w_expire   = 5'd0;
      for (int i = 32'sd0; i < NUM_NEEDS; i++) begin
         if (w_sec_tick && !w_mode_chg && !r_dead &&
             (r_cnt[i] == last_count(3'(i), sched.test_mode))) begin
            w_expire[i] = 1'b1;
         end else begin
            w_expire[i] = 1'b0;
         end
      end
   end

   // Arbitration: accepted care wins the update slot, otherwise round-robin decay
   always_comb begin
      w_care_acc                   = sched.care_valid & ~r_dead;
      w_care_hit                   = w_care_acc & (sched.care_sel <= 3'd4);
      {w_grant_valid, w_grant_idx} = rr_pick(r_pending, r_ptr);
      w_decay_go                   = w_grant_valid & ~w_care_acc & ~r_dead;
      w_grant_lvl                  = 3'd0;
      for (int i = 32'sd0; i < NUM_NEEDS; i++) begin
         if (w_grant_idx == 3'(i)) begin
            w_grant_lvl = r_lvl[i];
         end else begin
            w_grant_lvl = w_grant_lvl;
         end
      end
      if (w_decay_go) begin
         w_clear = 5'd1 << w_grant_idx;
      end else begin
         w_clear = 5'd0;
      end
      // A fresh expiry on the granted need re-arms it rather than being lost
      w_pending_nxt = (r_pending & ~w_clear) | w_expire;
   end

   // Prescaler, per-need second counters and registered copy of test_mode
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= 26'd0;
         r_mode  <= sched.test_mode;
         for (int i = 32'sd0; i < NUM_NEEDS; i++) begin
            r_cnt[i] <= 12'd0;
         end
      end else begin
         r_mode <= sched.test_mode;
         if (r_dead) begin
            r_presc <= r_presc;
         end else if (w_mode_chg) begin
            r_presc <= 26'd0;
            for (int i = 32'sd0; i < NUM_NEEDS; i++) begin
               r_cnt[i] <= 12'd0;
            end
         end else if (w_sec_tick) begin
            r_presc <= 26'd0;
            for (int i = 32'sd0; i < NUM_NEEDS; i++) begin
               if (w_expire[i]) begin
                  r_cnt[i] <= 12'd0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + 12'd1;
               end
            end
         end else begin
            r_presc <= r_presc + 26'd1;
         end
      end
   end

   // Pending flags, levels, health, death flag and update strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending   <= 5'd0;
         r_ptr       <= 3'd0;
         r_health    <= LVL_MAX;
         r_dead      <= 1'b0;
         r_upd_valid <= 1'b0;
         r_upd_idx   <= 3'd0;
         for (int i = 32'sd0; i < NUM_NEEDS; i++) begin
            r_lvl[i] <= LVL_MAX;
         end
      end else if (r_dead) begin
         // Frozen: only reset leaves this state
         r_pending   <= 5'd0;
         r_upd_valid <= 1'b0;
      end else begin
         r_pending   <= w_pending_nxt;
         r_upd_valid <= 1'b0;
         if (w_care_hit) begin
            for (int i = 32'sd0; i < NUM_NEEDS; i++) begin
               if (sched.care_sel == 3'(i)) begin
                  r_lvl[i] <= care_sum(r_lvl[i]);
               end else begin
                  r_lvl[i] <= r_lvl[i];
               end
            end
            r_upd_valid <= 1'b1;
            r_upd_idx   <= sched.care_sel;
         end else if (w_decay_go) begin
            for (int i = 32'sd0; i < NUM_NEEDS; i++) begin
               if ((w_grant_idx == 3'(i)) && (r_lvl[i] != 3'd0)) begin
                  r_lvl[i] <= r_lvl[i] - 3'd1;
               end else begin
                  r_lvl[i] <= r_lvl[i];
               end
            end
            if (w_grant_lvl != 3'd0) begin
               r_health <= r_health;
            end else if (r_health != 3'd0) begin
               r_health <= r_health - 3'd1;
            end else begin
               r_dead <= 1'b1;
            end
            r_upd_valid <= 1'b1;
            r_upd_idx   <= w_grant_idx;
            r_ptr       <= wrap5({1'b0, w_grant_idx} + 4'd1);
         end else begin
            r_upd_valid <= 1'b0;
         end
      end
   end

   assign sched.levels     = {r_lvl[4], r_lvl[3], r_lvl[2], r_lvl[1], r_lvl[0]};
   assign sched.health     = r_health;
   assign sched.dead       = r_dead;
   assign sched.care_ready = ~r_dead;
   assign sched.upd_valid  = r_upd_valid;
   assign sched.upd_idx    = r_upd_idx;

endmodule

// File: tb/tb_need_scheduler.sv
// tb_need_scheduler: directed checks of decay timing, care saturation,
// arbitration order, mode toggle, reset and the death sequence.
module tb_need_scheduler;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   checks;
   int   failures;
   int   pulses;
   bit   done;

   need_scheduler_if ia ();
   need_scheduler_if ib ();

   // Slow food timer, test period 3 for the mode-toggle case
   need_scheduler #(
      .TICK_DIV(32'd4), .SLEEP_PERIOD(32'd4095), .FOOD_PERIOD(32'd3),
      .BATH_PERIOD(32'd4095), .MUSIC_PERIOD(32'd4095), .EXERCISE_PERIOD(32'd4095),
      .TEST_PERIOD(32'd3), .CARE_STEP(32'd2)
   ) u_a (
      .clk(clk), .reset(rst_a), .sched(ia)
   );

   // Every need expires every second, fast seconds
   need_scheduler #(
      .TICK_DIV(32'd2), .SLEEP_PERIOD(32'd1), .FOOD_PERIOD(32'd1),
      .BATH_PERIOD(32'd1), .MUSIC_PERIOD(32'd1), .EXERCISE_PERIOD(32'd1),
      .TEST_PERIOD(32'd1), .CARE_STEP(32'd2)
   ) u_b (
      .clk(clk), .reset(rst_b), .sched(ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      ia.test_mode = 1'b0; ia.care_valid = 1'b0; ia.care_sel = 3'd0;
      ib.test_mode = 1'b0; ib.care_valid = 1'b0; ib.care_sel = 3'd0;

      // ---------------- reset state (A)
      step(1);
      check("rst_levels", 32'(ia.levels), 32'h7FFF);
      check("rst_health", 32'(ia.health), 32'd7);
      check("rst_dead", 32'(ia.dead), 32'd0);
      check("rst_upd_valid", 32'(ia.upd_valid), 32'd0);
      check("rst_upd_idx", 32'(ia.upd_idx), 32'd0);
      check("rst_care_ready", 32'(ia.care_ready), 32'd1);
      rst_a = 1'b0;                                  // edge 0

      // ---------------- basic decay: food at 3rd tick + 1, then every 12
      step(12);                                      // edge 12
      check("decay_pre_food", 32'(ia.levels[5:3]), 32'd7);
      check("decay_pre_upd", 32'(ia.upd_valid), 32'd0);
      step(1);                                       // edge 13
      check("decay1_food", 32'(ia.levels[5:3]), 32'd6);
      check("decay1_upd", 32'(ia.upd_valid), 32'd1);
      check("decay1_idx", 32'(ia.upd_idx), 32'd1);
      step(1);                                       // edge 14
      check("decay1_pulse_end", 32'(ia.upd_valid), 32'd0);
      step(11);                                      // edge 25
      check("decay2_food", 32'(ia.levels[5:3]), 32'd5);
      check("decay2_upd", 32'(ia.upd_valid), 32'd1);
      check("decay2_idx", 32'(ia.upd_idx), 32'd1);

      // ---------------- care: 5 -> 7
      step(1);                                       // edge 26
      ia.care_valid = 1'b1; ia.care_sel = 3'd1;
      step(1);                                       // edge 27
      ia.care_valid = 1'b0;
      check("care5_food", 32'(ia.levels[5:3]), 32'd7);
      check("care5_upd", 32'(ia.upd_valid), 32'd1);
      check("care5_idx", 32'(ia.upd_idx), 32'd1);
      step(10);                                      // edge 37
      check("decay3_food", 32'(ia.levels[5:3]), 32'd6);
      // care 6 -> saturate at 7
      ia.care_valid = 1'b1; ia.care_sel = 3'd1;
      step(1);                                       // edge 38
      check("care_sat_food", 32'(ia.levels[5:3]), 32'd7);
      check("care_sat_upd", 32'(ia.upd_valid), 32'd1);
      // out-of-range index: accepted, no change, no pulse
      ia.care_sel = 3'd5;
      step(1);                                       // edge 39
      ia.care_valid = 1'b0;
      check("care_sel5_upd", 32'(ia.upd_valid), 32'd0);
      check("care_sel5_levels", 32'(ia.levels), 32'h7FFF);
      check("care_sel5_idx_held", 32'(ia.upd_idx), 32'd1);
      step(46);                                      // edge 85
      check("decay_food3", 32'(ia.levels[5:3]), 32'd3);
      ia.care_valid = 1'b1; ia.care_sel = 3'd1;
      step(1);                                       // edge 86
      ia.care_valid = 1'b0;
      check("care3_food", 32'(ia.levels[5:3]), 32'd5);
      check("care3_upd", 32'(ia.upd_valid), 32'd1);

      // ---------------- mode toggle with food counter at 2 of 3
      step(6);                                       // edge 92
      ia.test_mode = 1'b1;
      step(5);                                       // edge 97
      check("toggle_no_old_expiry_upd", 32'(ia.upd_valid), 32'd0);
      check("toggle_no_old_expiry_food", 32'(ia.levels[5:3]), 32'd5);
      step(8);                                       // edge 105
      check("toggle_pending_only", 32'(ia.upd_valid), 32'd0);
      step(1);                                       // edge 106
      check("drain0_upd", 32'(ia.upd_valid), 32'd1);
      check("drain0_idx", 32'(ia.upd_idx), 32'd2);
      step(1);
      check("drain1_idx", 32'(ia.upd_idx), 32'd3);
      step(1);
      check("drain2_idx", 32'(ia.upd_idx), 32'd4);
      step(1);
      check("drain3_idx", 32'(ia.upd_idx), 32'd0);
      step(1);                                       // edge 110
      check("drain4_idx", 32'(ia.upd_idx), 32'd1);
      check("drain4_upd", 32'(ia.upd_valid), 32'd1);
      check("drain_levels", 32'(ia.levels), 32'({3'd6, 3'd6, 3'd6, 3'd4, 3'd6}));

      // ---------------- conflict and round robin (B)
      rst_b = 1'b0;                                  // F0
      step(1);                                       // F1
      check("b_idle_f1", 32'(ib.upd_valid), 32'd0);
      step(1);                                       // F2: all pending set
      check("b_idle_f2", 32'(ib.upd_valid), 32'd0);
      ib.care_valid = 1'b1; ib.care_sel = 3'd2;
      step(1);                                       // F3
      ib.care_valid = 1'b0;
      check("conf_care_upd", 32'(ib.upd_valid), 32'd1);
      check("conf_care_idx", 32'(ib.upd_idx), 32'd2);
      check("conf_care_levels", 32'(ib.levels), 32'h7FFF);
      for (int k = 0; k < 5; k++) begin
         step(1);                                    // F4..F8
         check("rr_upd", 32'(ib.upd_valid), 32'd1);
         check("rr_idx", 32'(ib.upd_idx), 32'(k));
      end
      check("rr_levels", 32'(ib.levels), 32'({5{3'd6}}));

      // ---------------- reset mid-drain
      rst_b = 1'b1;
      step(1);                                       // F9
      rst_b = 1'b0;
      check("midrst_levels", 32'(ib.levels), 32'h7FFF);
      check("midrst_health", 32'(ib.health), 32'd7);
      check("midrst_upd", 32'(ib.upd_valid), 32'd0);
      check("midrst_idx", 32'(ib.upd_idx), 32'd0);
      step(1);                                       // F10
      check("midrst_quiet1", 32'(ib.upd_valid), 32'd0);
      step(1);                                       // F11
      check("midrst_quiet2", 32'(ib.upd_valid), 32'd0);

      // ---------------- death: 35 level steps + 7 health steps + fatal
      pulses = 0;
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         step(1);
         if (ib.upd_valid) pulses++;
         if (ib.dead) done = 1'b1;
      end
      check("death_reached", 32'(ib.dead), 32'd1);
      check("death_pulse_count", 32'(pulses), 32'd43);
      check("death_upd", 32'(ib.upd_valid), 32'd1);
      check("death_levels", 32'(ib.levels), 32'd0);
      check("death_health", 32'(ib.health), 32'd0);
      check("death_care_ready", 32'(ib.care_ready), 32'd0);

      // ---------------- frozen for 100 cycles despite care
      ib.care_valid = 1'b1; ib.care_sel = 3'd0;
      pulses = 0;
      for (int c = 0; c < 100; c++) begin
         step(1);
         if (ib.upd_valid) pulses++;
      end
      ib.care_valid = 1'b0;
      check("frozen_pulses", 32'(pulses), 32'd0);
      check("frozen_levels", 32'(ib.levels), 32'd0);
      check("frozen_health", 32'(ib.health), 32'd0);
      check("frozen_dead", 32'(ib.dead), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/need_scheduler.md
# need_scheduler

Need-decay and care scheduler for the pet core. It time-divides the system clock into one-second ticks and runs five independent decay timers (sleep, food, bath, music, exercise). It arbitrates timer expiries and user care requests onto a single update port of the need-level register file, and owns the health level and death flag. The display/LCD path and the button-handling logic consume `levels`, `health` and `dead`.

## Interface
- `TICK_DIV`, 50_000_000 — clk cycles per one-second tick; legal range ≥1, fits 26 bits.
- `SLEEP_PERIOD`, 3600 — seconds per sleep decay step; legal range 1..4095.
- `FOOD_PERIOD`, 600 — seconds per food decay step.
- `BATH_PERIOD`, 1200 — seconds per bath decay step.
- `MUSIC_PERIOD`, 900 — seconds per music decay step.
- `EXERCISE_PERIOD`, 1800 — seconds per exercise decay step.
- `TEST_PERIOD`, 2 — seconds per decay step for every need while `test_mode`=1.
- `CARE_STEP`, 2 — level increment per accepted care request.

Ports:
- `clk` in 1 — single system clock.
- `reset` in 1 — synchronous, active-high reset.
- `test_mode` in 1 — selects `TEST_PERIOD` for all five timers.
- `care_valid` in 1 — care request.
- `care_sel` in 3 — need index: 0 sleep, 1 food, 2 bath, 3 music, 4 exercise.
- `care_ready` out 1 — equals `~dead`. A request is accepted when `care_valid & care_ready`.
- `levels` out 15 — five 3-bit levels packed with need *i* at bits [3i+2:3i].
- `health` out 3 — health level.
- `dead` out 1 — sticky death flag.
- `upd_valid` out 1 — one-cycle pulse, asserted the cycle a level or health change becomes visible.
- `upd_idx` out 3 — need index of the last update. Held between pulses.

## Operation
- **Reset values:** all levels 7, `health` 7, `dead` 0, `upd_valid` 0, `upd_idx` 0, prescaler 0, second counters 0, pending flags 0, round-robin pointer 0. Requests are ignored while `reset`=1.
- **Prescaler:** counts 0..`TICK_DIV`-1. `sec_tick` is high for one cycle when the count equals `TICK_DIV`-1, then the count wraps to 0.
- **Per-need timer *i*:** on `sec_tick` the counter increments. When the counter equals P*i*-1 it wraps to 0 and sets `pending[i]`. P*i* is `TEST_PERIOD` if `test_mode`, otherwise that need's period. Counters are 12 bits.
- **Pending saturation:** if `pending[i]` is already 1 at expiry, it stays 1. The extra expiry is dropped, not queued.
- **Mode toggle:** any change of `test_mode`, detected against a registered copy, clears all five counters and the prescaler. Pending flags are unaffected.
- **Arbiter:** at most one update per cycle. A valid care request has priority over decay.
  - If there is no care request, the arbiter grants the first set pending flag searching from the pointer upward, modulo 5.
  - After a decay grant of *i*, the pointer becomes (*i*+1) mod 5 and `pending[i]` clears.
- **Decay on need *i*:**
  - If `level[i]`>0, decrement `level[i]`.
  - Otherwise, if `health`>0, decrement `health`.
  - Otherwise set `dead`.
- **Care on need *i*:** `level[i]` becomes min(7, `level[i]`+`CARE_STEP`). `care_sel`>4 is accepted with no state change and no `upd_valid`.
- **Same-index conflict:** care and pending decay on the same *i* in the same cycle → care applies and `pending[i]` stays set. The decay is serviced on a later cycle.
- **Dead:** prescaler, counters and pending flags are frozen and pending flags are cleared. No level or health changes occur and `care_ready`=0. Only `reset` exits this state.
- **Health:** never increases; it recovers only via `reset`.

## Timing
- An accepted care request or a granted decay changes the register on the next clk edge. `upd_valid`/`upd_idx` assert in that same cycle, alongside the new value.
- **Expiry to update:** `pending[i]` sets on the edge after the expiring `sec_tick` cycle. With no contention the grant happens in the following cycle, and `levels` changes 2 cycles after `sec_tick`.
- **Worst case:** all five pending with no care are drained in 5 consecutive cycles. Continuous care starves decay indefinitely (by design).
- **Death transition:** `dead` rises on the edge of the fatal decay. `care_ready` falls in the same cycle, and `upd_valid` pulses with the index of the fatal need.
- **Reset:** `reset` asserted mid-drain discards all pending work. The reset values above hold on the first edge with `reset`=1.

## Test plan
- **Basic decay:** `TICK_DIV`=4, `FOOD_PERIOD`=3, other periods 4095, idle inputs → food drops 7→6 at the 3rd `sec_tick` and then every 12 cycles. `upd_idx`=1 on each pulse.
- **Care saturation:** food=6, pulse `care_valid` with `care_sel`=1 → food=7 (saturated) next cycle and `upd_valid`=1. Then set food=3 and care → 5.
- **Conflict and round-robin:** all periods=1, `TEST_PERIOD` unused, care on index 2 held one cycle coincident with all-pending → care on 2 first. Decays then follow in order 0,1,2,3,4 on consecutive cycles.
- **Death sequence:** `test_mode`=1, `TEST_PERIOD`=1, `TICK_DIV`=2, no care → levels reach 0, then health counts 7→0. The next decay sets `dead`, `care_ready`=0, and all outputs freeze for 100 cycles.
- **Mode toggle:** toggle `test_mode` when a counter is at 2 of 3 → the counter restarts, so the next expiry is a full `TEST_PERIOD` later.
- **Reset mid-operation:** assert `reset` for 1 cycle while 3 decays are pending → levels=7, `health`=7, no `upd_valid` for the next `TICK_DIV`×min(P) cycles.
